decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 177 +++++++++++++++++
 tb/tb_decode_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bus.
// The stage side uses the slave modport; the surrounding pipeline uses the master modport.
interface decode_stage_if;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInst;
    logic [31:0] inPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInst;
    logic [31:0] outPc;

    modport master (
        output inValid,
        output inInst,
        output inPc,
        output outReady,
        input  inReady,
        input  outValid,
        input  outInst,
        input  outPc
    );

    modport slave (
        input  inValid,
        input  inInst,
        input  inPc,
        input  outReady,
        output inReady,
        output outValid,
        output outInst,
        output outPc
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming fetch word, captured
// into a two-entry (main + skid) buffer so that inReady comes straight from a flop.
package decode_stage_pkg;
    typedef enum logic [2:0] {
        INST_TYPE_R,
        INST_TYPE_I,
        INST_TYPE_S,
        INST_TYPE_B,
        INST_TYPE_U,
        INST_TYPE_J
    } InstructionType;

    typedef struct packed {
        logic [31:0]    inst;
        logic [31:0]    pc;
        InstructionType itype;
        logic [31:0]    imm;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic           illegal;
    } entry_t;
endpackage

// Immediate generator: RV32I immediate layout selected by instruction format.
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0]    inst,
    input  InstructionType inst_type,
    output logic [31:0]    imm
);
    // Reassemble and sign-extend the immediate bits for the given format.
    always_comb begin
        imm = 32'd0;
        case (inst_type)
            INST_TYPE_I: imm = {{20{inst[31]}}, inst[31:20]};
            INST_TYPE_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            INST_TYPE_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            INST_TYPE_U: imm = {inst[31:12], 12'd0};
            INST_TYPE_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:     imm = 32'd0;
        endcase
    end
endmodule

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           flush,
    decode_stage_if.slave  bus,
    output InstructionType instructionType,
    output logic [31:0]    imm,
    output logic [4:0]     rd,
    output logic [4:0]     rs1,
    output logic [4:0]     rs2,
    output logic           illegal
);

    InstructionType dec_type;
    logic           dec_illegal;
    logic [31:0]    dec_imm;
    entry_t         dec_entry;

    entry_t         main_q;
    entry_t         skid_q;
    logic           main_valid;
    logic           skid_valid;

    logic           accept;
    logic           drain;

    // Opcode classification; unknown opcodes decode as I-format and are flagged.
    always_comb begin
        dec_type    = INST_TYPE_I;
        dec_illegal = 1'b0;
        case (bus.inInst[6:0])
            7'b0110011: dec_type = INST_TYPE_R;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: dec_type = INST_TYPE_I;
            7'b0100011: dec_type = INST_TYPE_S;
            7'b1100011: dec_type = INST_TYPE_B;
            7'b0110111,
            7'b0010111: dec_type = INST_TYPE_U;
            7'b1101111: dec_type = INST_TYPE_J;
            default: begin
                dec_type    = INST_TYPE_I;
                dec_illegal = 1'b1;
            end
        endcase
    end

    imm_gen imm_gen_submodule (
        .inst      (bus.inInst),
        .inst_type (dec_type),
        .imm       (dec_imm)
    );

    // Bundle the decoded fields for capture into either buffer entry.
    always_comb begin
        dec_entry         = '0;
        dec_entry.inst    = bus.inInst;
        dec_entry.pc      = bus.inPc;
        dec_entry.itype   = dec_type;
        dec_entry.imm     = dec_imm;
        dec_entry.rd      = bus.inInst[11:7];
        dec_entry.rs1     = bus.inInst[19:15];
        dec_entry.rs2     = bus.inInst[24:20];
        dec_entry.illegal = dec_illegal;
    end

    // Ready depends only on the skid flop, so no combinational path from outReady.
    assign accept = bus.inValid & ~skid_valid;
    assign drain  = main_valid & bus.outReady;

    // Main/skid buffer update; flush discards everything including this cycle's accept.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_q <= dec_entry;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec_entry;
                end
            end
        end else if (accept) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    // Present main when valid; otherwise a NOP with neutral fields so stale data never leaks.
    always_comb begin
        bus.inReady  = ~skid_valid;
        bus.outValid = main_valid;
        if (main_valid) begin
            bus.outInst     = main_q.inst;
            bus.outPc       = main_q.pc;
            instructionType = main_q.itype;
            imm             = main_q.imm;
            rd              = main_q.rd;
            rs1             = main_q.rs1;
            rs2             = main_q.rs2;
            illegal         = main_q.illegal;
        end else begin
            bus.outInst     = NOP_INST;
            bus.outPc       = 32'd0;
            instructionType = INST_TYPE_I;
            imm             = 32'd0;
            rd              = 5'd0;
            rs1             = 5'd0;
            rs2             = 5'd0;
            illegal         = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int NVEC = 10;

    localparam logic [31:0] VEC_INST [NVEC] = '{
        32'h00510093, 32'hFE112E23, 32'h0000007F, 32'h002081B3, 32'h00208463,
        32'hFFDFF06F, 32'h123452B7, 32'h0080A283, 32'h00008067, 32'hFFF0007F
    };
    localparam InstructionType VEC_TYPE [NVEC] = '{
        INST_TYPE_I, INST_TYPE_S, INST_TYPE_I, INST_TYPE_R, INST_TYPE_B,
        INST_TYPE_J, INST_TYPE_U, INST_TYPE_I, INST_TYPE_I, INST_TYPE_I
    };
    localparam logic [31:0] VEC_IMM [NVEC] = '{
        32'h00000005, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000008,
        32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'h00000000, 32'hFFFFFFFF
    };
    // {rd, rs1, rs2}
    localparam logic [14:0] VEC_REGS [NVEC] = '{
        {5'd1, 5'd2, 5'd5},  {5'd28, 5'd2, 5'd1}, {5'd0, 5'd0, 5'd0},  {5'd3, 5'd1, 5'd2},
        {5'd8, 5'd1, 5'd2},  {5'd0, 5'd31, 5'd29}, {5'd5, 5'd8, 5'd3}, {5'd5, 5'd1, 5'd8},
        {5'd0, 5'd1, 5'd0},  {5'd0, 5'd0, 5'd31}
    };
    localparam bit VEC_ILL [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic           flush = 1'b0;
    InstructionType instructionType;
    logic [31:0]    imm;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic           illegal;

    int n_checks = 0;
    int n_fail = 0;

    decode_stage_if bus ();

    decode_stage #(.NOP_INST(NOP)) dut (
        .clk             (clk),
        .rstN            (rstN),
        .flush           (flush),
        .bus             (bus),
        .instructionType (instructionType),
        .imm             (imm),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    task automatic drive_in(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.inValid = v;
        bus.inInst  = inst;
        bus.inPc    = pc;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        drive_in(1'b0, 32'd0, 32'd0);
        bus.outReady = 1'b0;
        #12;
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid got %0b want 0", bus.outValid); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady got %0b want 1", bus.inReady); end
        n_checks++; if (bus.outInst !== NOP) begin n_fail++; $display("FAIL reset_outInst got %h want %h", bus.outInst, NOP); end
        n_checks++; if (bus.outPc !== 32'd0) begin n_fail++; $display("FAIL reset_outPc got %h want 0", bus.outPc); end
        n_checks++; if (instructionType !== INST_TYPE_I) begin n_fail++; $display("FAIL reset_type got %0d want %0d", instructionType, INST_TYPE_I); end
        n_checks++; if (imm !== 32'd0) begin n_fail++; $display("FAIL reset_imm got %h want 0", imm); end
        n_checks++; if ({rd, rs1, rs2} !== 15'd0) begin n_fail++; $display("FAIL reset_regs got %h want 0", {rd, rs1, rs2}); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0b want 0", illegal); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_decode();
        bus.outReady = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive_in(1'b1, VEC_INST[i], 32'h1000 + 32'(i * 4));
            @(negedge clk);
            n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL dec%0d_outValid got %0b want 1", i, bus.outValid); end
            n_checks++; if (bus.outInst !== VEC_INST[i]) begin n_fail++; $display("FAIL dec%0d_outInst got %h want %h", i, bus.outInst, VEC_INST[i]); end
            n_checks++; if (bus.outPc !== 32'h1000 + 32'(i * 4)) begin n_fail++; $display("FAIL dec%0d_outPc got %h want %h", i, bus.outPc, 32'h1000 + 32'(i * 4)); end
            n_checks++; if (instructionType !== VEC_TYPE[i]) begin n_fail++; $display("FAIL dec%0d_type got %0d want %0d", i, instructionType, VEC_TYPE[i]); end
            n_checks++; if (imm !== VEC_IMM[i]) begin n_fail++; $display("FAIL dec%0d_imm got %h want %h", i, imm, VEC_IMM[i]); end
            n_checks++; if ({rd, rs1, rs2} !== VEC_REGS[i]) begin n_fail++; $display("FAIL dec%0d_regs got %h want %h", i, {rd, rs1, rs2}, VEC_REGS[i]); end
            n_checks++; if (illegal !== VEC_ILL[i]) begin n_fail++; $display("FAIL dec%0d_illegal got %0b want %0b", i, illegal, VEC_ILL[i]); end
        end
        drive_in(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL idle_outValid got %0b want 0", bus.outValid); end
        n_checks++; if (bus.outInst !== NOP) begin n_fail++; $display("FAIL idle_outInst got %h want %h", bus.outInst, NOP); end
        n_checks++; if (imm !== 32'd0) begin n_fail++; $display("FAIL idle_imm got %h want 0", imm); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL idle_illegal got %0b want 0", illegal); end
    endtask

    task automatic test_backpressure();
        bus.outReady = 1'b0;
        drive_in(1'b1, 32'h00100093, 32'h2000);
        @(negedge clk);
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_A got %0b want 1", bus.inReady); end
        n_checks++; if (bus.outInst !== 32'h00100093) begin n_fail++; $display("FAIL bp_head_A got %h want 00100093", bus.outInst); end
        drive_in(1'b1, 32'h00200113, 32'h2004);
        @(negedge clk);
        n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_B got %0b want 0", bus.inReady); end
        n_checks++; if (bus.outInst !== 32'h00100093) begin n_fail++; $display("FAIL bp_hold_A1 got %h want 00100093", bus.outInst); end
        drive_in(1'b1, 32'h00300193, 32'h2008);
        @(negedge clk);
        n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready_C_held got %0b want 0", bus.inReady); end
        n_checks++; if ({bus.outValid, bus.outInst, bus.outPc} !== {1'b1, 32'h00100093, 32'h2000}) begin
            n_fail++; $display("FAIL bp_hold_A2 got %0b/%h/%h want 1/00100093/00002000", bus.outValid, bus.outInst, bus.outPc);
        end
        bus.outReady = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.outValid, bus.outInst, bus.outPc} !== {1'b1, 32'h00200113, 32'h2004}) begin
            n_fail++; $display("FAIL bp_out_B got %0b/%h/%h want 1/00200113/00002004", bus.outValid, bus.outInst, bus.outPc);
        end
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen got %0b want 1", bus.inReady); end
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0);
        n_checks++; if ({bus.outValid, bus.outInst, bus.outPc} !== {1'b1, 32'h00300193, 32'h2008}) begin
            n_fail++; $display("FAIL bp_out_C got %0b/%h/%h want 1/00300193/00002008", bus.outValid, bus.outInst, bus.outPc);
        end
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", bus.outValid); end
    endtask

    task automatic test_flush();
        bus.outReady = 1'b0;
        drive_in(1'b1, 32'h00400213, 32'h3000);
        @(negedge clk);
        drive_in(1'b1, 32'h00500293, 32'h3004);
        @(negedge clk);
        n_checks++; if ({bus.outValid, bus.inReady} !== 2'b10) begin n_fail++; $display("FAIL flush_full got %b want 10", {bus.outValid, bus.inReady}); end
        drive_in(1'b1, 32'h00600313, 32'h3008);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive_in(1'b0, 32'd0, 32'd0);
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush_outValid got %0b want 0", bus.outValid); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL flush_inReady got %0b want 1", bus.inReady); end
        n_checks++; if (bus.outInst !== NOP) begin n_fail++; $display("FAIL flush_outInst got %h want %h", bus.outInst, NOP); end
        drive_in(1'b1, 32'h00700393, 32'h300C);
        @(negedge clk);
        drive_in(1'b1, 32'h00800413, 32'h3010);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive_in(1'b0, 32'd0, 32'd0);
        bus.outReady = 1'b1;
        n_checks++; if ({bus.outValid, bus.inReady} !== 2'b01) begin n_fail++; $display("FAIL flush2_state got %b want 01", {bus.outValid, bus.inReady}); end
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush2_no_late got %0b want 0", bus.outValid); end
        drive_in(1'b1, 32'h00900493, 32'h3014);
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0);
        n_checks++; if ({bus.outValid, bus.outInst, bus.outPc} !== {1'b1, 32'h00900493, 32'h3014}) begin
            n_fail++; $display("FAIL flush_resume got %0b/%h/%h want 1/00900493/00003014", bus.outValid, bus.outInst, bus.outPc);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.outReady = 1'b0;
        drive_in(1'b1, 32'hFE112E23, 32'h4000);
        @(negedge clk);
        drive_in(1'b1, 32'hFFF0007F, 32'h4004);
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0);
        n_checks++; if ({bus.outValid, bus.inReady} !== 2'b10) begin n_fail++; $display("FAIL ar_full got %b want 10", {bus.outValid, bus.inReady}); end
        #2;
        rstN = 1'b0;
        #1;
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL ar_outValid got %0b want 0", bus.outValid); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL ar_inReady got %0b want 1", bus.inReady); end
        n_checks++; if ({bus.outInst, bus.outPc} !== {NOP, 32'd0}) begin n_fail++; $display("FAIL ar_inst_pc got %h/%h want %h/0", bus.outInst, bus.outPc, NOP); end
        n_checks++; if (instructionType !== INST_TYPE_I) begin n_fail++; $display("FAIL ar_type got %0d want %0d", instructionType, INST_TYPE_I); end
        n_checks++; if ({imm, rd, rs1, rs2, illegal} !== 48'd0) begin n_fail++; $display("FAIL ar_fields got %h want 0", {imm, rd, rs1, rs2, illegal}); end
        @(negedge clk);
        rstN = 1'b1;
        bus.outReady = 1'b1;
        drive_in(1'b1, 32'h00A00513, 32'h5000);
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0);
        n_checks++; if ({bus.outValid, bus.outInst, bus.outPc} !== {1'b1, 32'h00A00513, 32'h5000}) begin
            n_fail++; $display("FAIL ar_first_accept got %0b/%h/%h want 1/00a00513/00005000", bus.outValid, bus.outInst, bus.outPc);
        end
        @(negedge clk);
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL ar_no_stale got %0b want 0", bus.outValid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
